// File: rtl/target_placement_ctrl_if.sv
// rtl/target_placement_ctrl_if.sv - occupancy query bus between placement controller and body checker
interface target_placement_ctrl_if;
  logic        occ_req;
  logic [14:0] occ_addr;
  logic        occ_ack;
  logic        occ_hit;

  modport master (output occ_req, output occ_addr, input occ_ack, input occ_hit);
  modport slave  (input occ_req, input occ_addr, output occ_ack, output occ_hit);
endinterface

// File: rtl/target_placement_ctrl.sv
// rtl/target_placement_ctrl.sv - picks a free food cell: random draws, then raster-scan fallback
module target_placement_ctrl #(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 120,
  parameter int MAX_TRIES = 16,
  parameter int INIT_X    = 80,
  parameter int INIT_Y    = 60
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            target_ate,
  input  logic [14:0]                     rnd_in,
  target_placement_ctrl_if.master         occ,
  output logic [14:0]                     target_addr,
  output logic                            target_valid,
  output logic                            place_busy,
  output logic                            grid_full,
  output logic [7:0]                      target_count
);

  localparam logic [7:0]  XM        = 8'(X_MAX);
  localparam logic [6:0]  YM        = 7'(Y_MAX);
  localparam logic [6:0]  Y_LAST    = 7'(Y_MAX - 1);
  localparam logic [7:0]  TRIES_MAX = 8'(MAX_TRIES);
  localparam logic [14:0] GRID      = 15'(X_MAX * Y_MAX);
  localparam logic [14:0] INIT_ADDR = {8'(INIT_X), 7'(INIT_Y)};

  typedef enum logic [2:0] {IDLE, SAMPLE, QUERY, SCAN, FULL} state_t;

  state_t      state;
  logic        ate_q;
  logic [14:0] cand;
  logic [7:0]  tries;
  logic [14:0] scan_cnt;
  logic        scan_mode;

  logic        ate_rise;
  logic        rnd_oor;
  logic        cand_oor;
  logic [7:0]  tries_nx;
  logic [7:0]  x_inc;
  logic [14:0] scan_next;

  assign ate_rise = target_ate & ~ate_q;
  assign rnd_oor  = (rnd_in[14:7] >= XM) || (rnd_in[6:0] >= YM);
  assign cand_oor = (cand[14:7] >= XM) || (cand[6:0] >= YM);
  assign tries_nx = tries + 8'd1;
  assign x_inc    = cand[14:7] + 8'd1;

  // Raster order: x fastest, y wraps at the bottom row back to the top.
  always_comb begin
    scan_next = 15'd0;
    if (!cand_oor) begin
      if (x_inc == XM)
        scan_next = {8'd0, (cand[6:0] == Y_LAST) ? 7'd0 : cand[6:0] + 7'd1};
      else
        scan_next = {x_inc, cand[6:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ate_q        <= 1'b0;
      cand         <= 15'd0;
      tries        <= 8'd0;
      scan_cnt     <= 15'd0;
      scan_mode    <= 1'b0;
      occ.occ_req  <= 1'b0;
      occ.occ_addr <= 15'd0;
      target_addr  <= INIT_ADDR;
      target_valid <= 1'b1;
      place_busy   <= 1'b0;
      grid_full    <= 1'b0;
      target_count <= 8'd0;
    end else begin
      ate_q <= target_ate;
      case (state)
        IDLE: begin
          if (ate_rise) begin
            target_valid <= 1'b0;
            place_busy   <= 1'b1;
            if (target_count != 8'hff)
              target_count <= target_count + 8'd1;
            tries     <= 8'd0;
            scan_mode <= 1'b0;
            // Each placement gets a fresh full-grid sweep budget.
            scan_cnt  <= 15'd0;
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          cand <= rnd_in;
          if (rnd_oor) begin
            tries <= tries_nx;
            if (tries_nx >= TRIES_MAX) begin
              scan_mode <= 1'b1;
              state     <= SCAN;
            end
          end else begin
            occ.occ_req  <= 1'b1;
            occ.occ_addr <= rnd_in;
            state        <= QUERY;
          end
        end
        QUERY: begin
          if (occ.occ_ack) begin
            occ.occ_req <= 1'b0;
            if (!occ.occ_hit) begin
              target_addr  <= cand;
              target_valid <= 1'b1;
              place_busy   <= 1'b0;
              state        <= IDLE;
            end else if (scan_mode) begin
              state <= SCAN;
            end else begin
              tries <= tries_nx;
              if (tries_nx >= TRIES_MAX) begin
                scan_mode <= 1'b1;
                state     <= SCAN;
              end else begin
                state <= SAMPLE;
              end
            end
          end
        end
        SCAN: begin
          scan_cnt <= scan_cnt + 15'd1;
          // Every cell has been queried once already: nothing is free.
          if (scan_cnt == GRID) begin
            grid_full    <= 1'b1;
            target_valid <= 1'b0;
            place_busy   <= 1'b0;
            state        <= FULL;
          end else begin
            cand         <= scan_next;
            occ.occ_req  <= 1'b1;
            occ.occ_addr <= scan_next;
            state        <= QUERY;
          end
        end
        FULL: state <= FULL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_placement_ctrl.sv
// tb/tb_target_placement_ctrl.sv - directed checks of target placement on full-size and 4x2 grids
module tb_target_placement_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size grid instance, MAX_TRIES = 4
  logic        rst, target_ate, ack_en;
  logic [14:0] rnd_in, free_addr;
  logic [14:0] target_addr;
  logic        target_valid, place_busy, grid_full;
  logic [7:0]  target_count;
  target_placement_ctrl_if bus ();
  assign bus.occ_ack = bus.occ_req & ack_en;
  assign bus.occ_hit = (bus.occ_addr != free_addr);

  target_placement_ctrl #(.X_MAX(160), .Y_MAX(120), .MAX_TRIES(4), .INIT_X(80), .INIT_Y(60)) dut (
    .clk(clk), .rst(rst), .target_ate(target_ate), .rnd_in(rnd_in), .occ(bus.master),
    .target_addr(target_addr), .target_valid(target_valid), .place_busy(place_busy),
    .grid_full(grid_full), .target_count(target_count));

  // 4x2 grid instance, body checker always reports occupied
  logic        rst2, target_ate2;
  logic [14:0] rnd_in2;
  logic [14:0] target_addr2;
  logic        target_valid2, place_busy2, grid_full2;
  logic [7:0]  target_count2;
  target_placement_ctrl_if bus2 ();
  assign bus2.occ_ack = bus2.occ_req;
  assign bus2.occ_hit = 1'b1;

  target_placement_ctrl #(.X_MAX(4), .Y_MAX(2), .MAX_TRIES(4), .INIT_X(1), .INIT_Y(1)) dut2 (
    .clk(clk), .rst(rst2), .target_ate(target_ate2), .rnd_in(rnd_in2), .occ(bus2.master),
    .target_addr(target_addr2), .target_valid(target_valid2), .place_busy(place_busy2),
    .grid_full(grid_full2), .target_count(target_count2));

  logic [14:0] qlog[$];
  logic [14:0] qlog2[$];
  always @(posedge clk) begin
    if (bus.occ_req && bus.occ_ack) qlog.push_back(bus.occ_addr);
    if (bus2.occ_req && bus2.occ_ack) qlog2.push_back(bus2.occ_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse target_ate for one cycle and count clocks until target_valid returns.
  task automatic place(output int cyc);
    @(negedge clk);
    target_ate = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) target_ate = 1'b0;
    end while (!target_valid && cyc < 60);
  endtask

  typedef struct {
    logic [14:0] rnd;
    logic [14:0] free;
    logic [14:0] exp_addr;
    int          exp_cyc;
    int          exp_nq;
  } vec_t;

  vec_t vecs[6];
  int   cyc;
  int   exp_count;
  logic req_seen;
  logic [14:0] exp_scan[8];

  initial begin
    // {x,y} packed as x*128 + y
    vecs[0] = '{15'd1300,  15'd1300,  15'd1300,  3, 1};  // {10,20}
    vecs[1] = '{15'd0,     15'd0,     15'd0,     3, 1};  // {0,0}
    vecs[2] = '{15'd20471, 15'd20471, 15'd20471, 3, 1};  // {159,119}
    vecs[3] = '{15'd20480, 15'd0,     15'd0,     7, 1};  // {160,0} x out of range
    vecs[4] = '{15'd120,   15'd0,     15'd0,     7, 1};  // {0,120} y out of range
    vecs[5] = '{15'd32767, 15'd128,   15'd128,   9, 2};  // {255,127}, {0,0} occupied
    exp_scan = '{15'd257, 15'd385, 15'd0, 15'd128, 15'd256, 15'd384, 15'd1, 15'd129};

    rst = 1'b1; rst2 = 1'b1;
    target_ate = 1'b0; target_ate2 = 1'b0;
    ack_en = 1'b1; rnd_in = 15'd0; rnd_in2 = 15'd129; free_addr = 15'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // Reset release
    tick();
    chk("reset_target_addr", target_addr, 15'd10300);
    chk("reset_target_valid", target_valid, 1'b1);
    chk("reset_target_count", target_count, 8'd0);
    chk("reset_grid_full", grid_full, 1'b0);
    chk("reset_place_busy", place_busy, 1'b0);
    req_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      req_seen = req_seen | bus.occ_req;
    end
    chk("idle_no_occ_req", req_seen, 1'b0);

    // Single placements from the vector table
    exp_count = 0;
    foreach (vecs[i]) begin
      rnd_in = vecs[i].rnd;
      free_addr = vecs[i].free;
      qlog.delete();
      place(cyc);
      exp_count++;
      chk($sformatf("vec%0d_target_addr", i), target_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_queries", i), qlog.size(), vecs[i].exp_nq);
      chk($sformatf("vec%0d_count", i), target_count, exp_count);
      chk($sformatf("vec%0d_busy", i), place_busy, 1'b0);
    end

    // Out-of-range for two draws, then {3,4}
    qlog.delete();
    free_addr = 15'd388;
    rnd_in = 15'd25605;  // {200,5}
    @(negedge clk);
    target_ate = 1'b1;
    tick();
    target_ate = 1'b0;
    tick();
    tick();
    rnd_in = 15'd388;
    cyc = 0;
    while (!target_valid && cyc < 20) begin tick(); cyc++; end
    exp_count++;
    chk("oor_query_count", qlog.size(), 1);
    chk("oor_query_addr", (qlog.size() > 0) ? qlog[0] : 15'h7fff, 15'd388);
    chk("oor_target_addr", target_addr, 15'd388);

    // Occupied random draws fall back to the raster scan
    qlog.delete();
    rnd_in = 15'd20471;  // {159,119}
    free_addr = 15'd128;
    place(cyc);
    exp_count++;
    chk("fallback_query_count", qlog.size(), 6);
    chk("fallback_rand_last", (qlog.size() > 3) ? qlog[3] : 15'h7fff, 15'd20471);
    chk("fallback_scan0", (qlog.size() > 4) ? qlog[4] : 15'h7fff, 15'd0);
    chk("fallback_scan1", (qlog.size() > 5) ? qlog[5] : 15'h7fff, 15'd128);
    chk("fallback_target_addr", target_addr, 15'd128);
    chk("fallback_latency", cyc, 13);

    // TARGET_ATE held high for ten cycles
    qlog.delete();
    rnd_in = 15'd1300;
    free_addr = 15'd1300;
    @(negedge clk);
    target_ate = 1'b1;
    repeat (10) tick();
    target_ate = 1'b0;
    repeat (3) tick();
    exp_count++;
    chk("held_ate_queries", qlog.size(), 1);
    chk("held_ate_count", target_count, exp_count);
    chk("held_ate_valid", target_valid, 1'b1);

    // Second rising edge while waiting in QUERY is dropped
    qlog.delete();
    ack_en = 1'b0;
    rnd_in = 15'd645;
    free_addr = 15'd645;
    @(negedge clk);
    target_ate = 1'b1;
    tick();
    target_ate = 1'b0;
    repeat (3) tick();
    chk("wait_occ_req", bus.occ_req, 1'b1);
    chk("wait_occ_addr", bus.occ_addr, 15'd645);
    target_ate = 1'b1;
    tick();
    target_ate = 1'b0;
    rnd_in = 15'd1300;
    repeat (2) tick();
    chk("wait_occ_addr_stable", bus.occ_addr, 15'd645);
    ack_en = 1'b1;
    tick();
    chk("ack_req_drop", bus.occ_req, 1'b0);
    repeat (6) tick();
    exp_count++;
    chk("dropped_edge_count", target_count, exp_count);
    chk("dropped_edge_queries", qlog.size(), 1);
    chk("dropped_edge_target", target_addr, 15'd645);
    chk("dropped_edge_busy", place_busy, 1'b0);

    // Asynchronous reset in the middle of a query
    ack_en = 1'b0;
    rnd_in = 15'd1300;
    @(negedge clk);
    target_ate = 1'b1;
    tick();
    target_ate = 1'b0;
    repeat (2) tick();
    chk("pre_reset_occ_req", bus.occ_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_occ_req", bus.occ_req, 1'b0);
    chk("async_reset_target", target_addr, 15'd10300);
    chk("async_reset_count", target_count, 8'd0);
    chk("async_reset_valid", target_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;

    // Fully occupied 4x2 grid
    qlog2.delete();
    @(negedge clk);
    target_ate2 = 1'b1;
    tick();
    target_ate2 = 1'b0;
    cyc = 0;
    while (!grid_full2 && cyc < 200) begin tick(); cyc++; end
    chk("full_grid_full", grid_full2, 1'b1);
    chk("full_valid", target_valid2, 1'b0);
    chk("full_busy", place_busy2, 1'b0);
    chk("full_query_count", qlog2.size(), 12);
    for (int i = 0; i < 8; i++)
      chk($sformatf("full_scan%0d", i), (qlog2.size() > 4 + i) ? qlog2[4 + i] : 15'h7fff, exp_scan[i]);
    @(negedge clk);
    target_ate2 = 1'b1;
    tick();
    target_ate2 = 1'b0;
    repeat (6) tick();
    chk("full_ignores_ate_queries", qlog2.size(), 12);
    chk("full_ignores_ate_count", target_count2, 8'd1);
    chk("full_sticky", grid_full2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/target_placement_ctrl.md
# target_placement_ctrl

Sequencer that turns the free-running random address into a legal food target for the snake game. On a "target eaten" event it draws random candidates, range-checks them against the 160x120 play grid, and asks the snake-body occupancy checker whether each candidate is free. It then commits the first free cell as the new target. If random draws keep failing, it falls back to a deterministic raster scan; if the whole grid is occupied, it reports a full grid. It sits between the random generator, the snake body/collision logic and the VGA target renderer.

## Interface
- X_MAX, 160, number of columns; legal x is 0..X_MAX-1 (x held in addr[14:7]).
- Y_MAX, 120, number of rows; legal y is 0..Y_MAX-1 (y held in addr[6:0]).
- MAX_TRIES, 16, number of failed random attempts before scan mode (1..255).
- INIT_X, 80, target x after reset.
- INIT_Y, 60, target y after reset.

- CLK  in  1  system clock. One clock domain only.
- RESET  in  1  asynchronous, active-high reset.
- TARGET_ATE  in  1  snake head reached target. Acted on at its rising edge.
- RND_IN  in  15  free-running random word {lfsr8, lfsr7}. Any value is legal.
- OCC_REQ  out  1  occupancy query request.
- OCC_ADDR  out  15  candidate {x,y} under query.
- OCC_ACK  in  1  occupancy answer valid.
- OCC_HIT  in  1  candidate lies on the snake body. Qualified by OCC_ACK.
- TARGET_ADDR  out  15  current target {x[7:0], y[6:0]}.
- TARGET_VALID  out  1  TARGET_ADDR is a committed, free cell.
- PLACE_BUSY  out  1  placement in progress.
- GRID_FULL  out  1  no free cell exists. Sticky until RESET.
- TARGET_COUNT  out  8  targets eaten. Saturates at 255.

## Operation
- FSM states: IDLE, SAMPLE, QUERY, SCAN, FULL. All outputs are registered.
- Reset values:
  - state = IDLE, TARGET_ADDR = {INIT_X, INIT_Y}, TARGET_VALID = 1.
  - OCC_REQ = 0, OCC_ADDR = 0, PLACE_BUSY = 0, GRID_FULL = 0, TARGET_COUNT = 0.
  - tries = 0, scan_cnt = 0, scan_mode = 0.
- Edge detect: ate_rise = TARGET_ATE & ~ate_q, where ate_q is a register that resets to 0. Edges seen outside IDLE are dropped; there is no queue.
- IDLE, on ate_rise:
  - TARGET_VALID -> 0, PLACE_BUSY -> 1.
  - TARGET_COUNT increments (saturating at 255); tries = 0, scan_mode = 0.
  - Go to SAMPLE.
- SAMPLE:
  - Latch cand = RND_IN.
  - If cand x >= X_MAX or y >= Y_MAX: reject and increment tries. If tries reaches MAX_TRIES, go to SCAN with scan_mode = 1; otherwise stay in SAMPLE.
  - If cand is in range: go to QUERY.
- QUERY:
  - OCC_REQ = 1 and OCC_ADDR = cand, both held stable until a cycle with OCC_ACK = 1.
  - OCC_ACK with OCC_HIT = 0: TARGET_ADDR = cand, TARGET_VALID = 1, PLACE_BUSY = 0, OCC_REQ = 0, go to IDLE.
  - OCC_ACK with OCC_HIT = 1 and scan_mode = 1: go to SCAN.
  - OCC_ACK with OCC_HIT = 1 and scan_mode = 0: increment tries; go to SCAN with scan_mode = 1 if tries reaches MAX_TRIES, otherwise back to SAMPLE.
  - OCC_REQ is 0 in the cycle after OCC_ACK is seen.
- SCAN (one cycle):
  - If cand is out of range, cand = {0,0}.
  - Otherwise x+1; when x+1 == X_MAX, x = 0 and y = y+1, with y wrapping from Y_MAX-1 to 0.
  - scan_cnt increments; when scan_cnt reaches X_MAX*Y_MAX (15-bit counter, 19200), go to FULL. Otherwise go to QUERY.
- FULL: GRID_FULL = 1, TARGET_VALID = 0, PLACE_BUSY = 0. The block exits FULL only on RESET.
- Ignored inputs: OCC_ACK and OCC_HIT outside QUERY; RND_IN outside SAMPLE.
- Arithmetic: x and y compare unsigned; tries is 8 bits; scan_cnt is 15 bits; no carry from y into x.

## Timing
- Fastest placement:
  - ate_rise at cycle n.
  - SAMPLE at n+1.
  - QUERY with OCC_REQ high at n+2; OCC_ACK with no hit arrives the same cycle.
  - TARGET_VALID = 1 with the new TARGET_ADDR at n+3.
- Each range reject costs 1 cycle. Each occupied query costs 1 cycle plus the OCC_ACK wait. Each scan step costs 1 cycle plus the query.
- TARGET_ADDR changes only on commit, so it is stable whenever TARGET_VALID = 1.
- An asynchronous RESET mid-placement takes effect immediately: OCC_REQ drops, the target returns to INIT, and TARGET_COUNT clears.

## Test plan
- Reset release:
  - TARGET_ADDR = 10300 ({80,60}), TARGET_VALID = 1, TARGET_COUNT = 0, GRID_FULL = 0.
  - No OCC_REQ is issued while TARGET_ATE stays 0.
- Clean hit:
  - RND_IN = {8'd10, 7'd20}, pulse TARGET_ATE at n, OCC_ACK with no hit at n+2.
  - TARGET_ADDR = 1300, TARGET_VALID = 1 at n+3, TARGET_COUNT = 1.
- Out-of-range then valid:
  - RND_IN = {8'd200, 7'd5} for 2 cycles, then {8'd3, 7'd4}.
  - OCC_ADDR = 388 (the first and only query), commit 388; out-of-range values are never sent.
- Occupied fallback, MAX_TRIES = 4:
  - OCC_HIT = 1 for 4 random candidates (last one {159,119}).
  - The next queries are {0,0}, then {1,0}.
  - OCC_HIT = 0 on {1,0}: commit TARGET_ADDR = 128.
- Full grid, small parameters X_MAX = 4, Y_MAX = 2:
  - OCC_HIT is always 1.
  - After exactly 8 scan queries: GRID_FULL = 1, TARGET_VALID = 0, PLACE_BUSY = 0; further TARGET_ATE pulses are ignored.
- Hazards:
  - TARGET_ATE held high for 10 cycles produces exactly one placement; a second rising edge during QUERY is dropped.
  - RESET asserted while OCC_REQ = 1 drops OCC_REQ in the same cycle, and TARGET_ADDR returns to 10300.
